// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction prefetch byte queue driving the arbiter's instruction master port
// Optional PREFETCH_STALL_EN adds stall_fetch, which holds off new fetches while asserted.
module instr_prefetch_queue #(
   parameter int          DEPTH    = 6,
   parameter logic [15:0] RESET_CS = 16'hFFFF,
   parameter logic [15:0] RESET_IP = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_new_ip,
   input  logic [15:0] new_cs,
   input  logic [15:0] new_ip,
   input  logic        fifo_rd_en,
   output logic [7:0]  fifo_rd_data,
   output logic        fifo_empty,
   output logic [18:0] instr_m_addr,
   input  logic [15:0] instr_m_data_in,
   output logic        instr_m_access,
   input  logic        instr_m_ack,
`ifdef PREFETCH_STALL_EN
   input  logic        stall_fetch,
`endif
   output logic        instr_m_wr_en,
   output logic [1:0]  instr_m_bytesel
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] ABORT = 2'd2;

   localparam int          PW      = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
   localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

   logic [1:0]    state;
   logic [15:0]   fetch_cs;
   logic [15:0]   fetch_ip;
   logic [3:0]    count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [7:0]    mem [DEPTH];

   logic [19:0]   phys;
   logic [4:0]    free;
   logic          stalled;
   logic          start;
   logic          accept;
   logic          push_lo;
   logic          push_hi;
   logic          pop;
   logic [PW-1:0] wr_ptr_hi;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

`ifdef PREFETCH_STALL_EN
   assign stalled = stall_fetch;
`else
   assign stalled = 1'b0;
`endif

   assign phys = {fetch_cs, 4'b0000} + {4'b0000, fetch_ip};
   assign free = DEPTH_L - {1'b0, count};

   // A new fetch is only started when the whole returned payload is guaranteed to fit.
   assign start  = (state == IDLE) && !load_new_ip && !stalled &&
                   (fetch_ip[0] ? (free >= 5'd1) : (free >= 5'd2));
   assign accept = (state == FETCH) && instr_m_ack && !load_new_ip;
   assign push_hi = accept;
   assign push_lo = accept && (instr_m_bytesel == 2'b11);
   assign pop     = fifo_rd_en && (count != 4'd0) && !load_new_ip;
   assign wr_ptr_hi = push_lo ? ptr_inc(wr_ptr) : wr_ptr;

   assign fifo_empty    = (count == 4'd0);
   assign fifo_rd_data  = fifo_empty ? 8'h00 : mem[rd_ptr];
   assign instr_m_wr_en = 1'b0;

   always_ff @(posedge clk) begin
      if (push_lo) mem[wr_ptr] <= instr_m_data_in[7:0];
      if (push_hi) mem[wr_ptr_hi] <= instr_m_data_in[15:8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         fetch_cs        <= RESET_CS;
         fetch_ip        <= RESET_IP;
         count           <= 4'd0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         instr_m_access  <= 1'b0;
         instr_m_addr    <= 19'd0;
         instr_m_bytesel <= 2'b00;
      end else begin
         if (load_new_ip) begin
            fetch_cs <= new_cs;
            fetch_ip <= new_ip;
            count    <= 4'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            count <= count + {3'b000, push_lo} + {3'b000, push_hi} - {3'b000, pop};
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push_hi) wr_ptr <= ptr_inc(wr_ptr_hi);
            if (accept) fetch_ip <= fetch_ip + (push_lo ? 16'd2 : 16'd1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  instr_m_access  <= 1'b1;
                  instr_m_addr    <= phys[19:1];
                  instr_m_bytesel <= fetch_ip[0] ? 2'b10 : 2'b11;
                  state           <= FETCH;
               end
            end
            FETCH: begin
               if (instr_m_ack) begin
                  instr_m_access <= 1'b0;
                  state          <= IDLE;
               end else if (load_new_ip) begin
                  state <= ABORT;
               end
            end
            ABORT: begin
               // Granted cycle must run to completion; its data is simply dropped.
               if (instr_m_ack) begin
                  instr_m_access <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               instr_m_access <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - randomized bench for instr_prefetch_queue against a byte-queue reference model
module tb_instr_prefetch_queue;

   localparam int DEPTH = 6;

   logic        clk;
   logic        reset;
   logic        load_new_ip;
   logic [15:0] new_cs;
   logic [15:0] new_ip;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data;
   logic        fifo_empty;
   logic [18:0] instr_m_addr;
   logic [15:0] instr_m_data_in;
   logic        instr_m_access;
   logic        instr_m_ack;
   logic        instr_m_wr_en;
   logic [1:0]  instr_m_bytesel;
`ifdef PREFETCH_STALL_EN
   logic        stall_fetch;
`endif

   instr_prefetch_queue #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .load_new_ip     (load_new_ip),
      .new_cs          (new_cs),
      .new_ip          (new_ip),
      .fifo_rd_en      (fifo_rd_en),
      .fifo_rd_data    (fifo_rd_data),
      .fifo_empty      (fifo_empty),
      .instr_m_addr    (instr_m_addr),
      .instr_m_data_in (instr_m_data_in),
      .instr_m_access  (instr_m_access),
      .instr_m_ack     (instr_m_ack),
`ifdef PREFETCH_STALL_EN
      .stall_fetch     (stall_fetch),
`endif
      .instr_m_wr_en   (instr_m_wr_en),
      .instr_m_bytesel (instr_m_bytesel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   logic [7:0]  q[$];
   logic [15:0] m_cs, m_ip;
   bit          req_active, req_stale;
   logic [18:0] req_addr;
   logic [1:0]  req_bs;
   int          ack_wait;
   bit          prev_access, start_exp, just_acked;
   int          n_fetch = 0;
   logic [18:0] addr_log[$];
   logic [1:0]  bs_log[$];

   // stimulus knobs
   int pop_pct = 0;
   int ld_pct = 0;
   int ack_min = 0;
   int ack_max = 3;
   int stall_mode = 0;
   bit stall_v = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [18:0] a);
      if (a == 19'h7FFF8) return 16'h3412;
      return {a[7:0] ^ a[15:8], a[7:0] + 8'h11};
   endfunction

   function automatic logic [18:0] exp_addr(input logic [15:0] cs, input logic [15:0] ip);
      logic [19:0] p;
      p = {cs, 4'h0} + {4'h0, ip};
      return p[19:1];
   endfunction

   task automatic reset_dut();
      reset = 1'b1;
      load_new_ip = 1'b0;
      fifo_rd_en = 1'b0;
      instr_m_ack = 1'b0;
      #1;
      chk("rst_access", instr_m_access, 1'b0);
      chk("rst_addr", instr_m_addr, 19'd0);
      chk("rst_bytesel", instr_m_bytesel, 2'b00);
      chk("rst_empty", fifo_empty, 1'b1);
      chk("rst_rd_data", fifo_rd_data, 8'h00);
      stall_v = (stall_mode == 1);
`ifdef PREFETCH_STALL_EN
      stall_fetch = stall_v;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      m_cs = 16'hFFFF;
      m_ip = 16'h0000;
      req_active = 1'b0;
      req_stale = 1'b0;
      just_acked = 1'b0;
      prev_access = 1'b0;
      start_exp = !stall_v;
   endtask

   // One clock: check observed outputs, pick inputs, advance the model across the coming edge.
   task automatic step(input bit force_ld, input logic [15:0] lcs, input logic [15:0] lip);
      bit ld, rd, ack;
      logic [15:0] w;
      @(negedge clk);
      chk("empty", fifo_empty, q.size() == 0);
      if (q.size() != 0) chk("rd_data", fifo_rd_data, q[0]);
      chk("wr_en", instr_m_wr_en, 1'b0);
      if (just_acked) chk("gap", instr_m_access, 1'b0);
      else if (!prev_access) chk("start", instr_m_access, start_exp);
      if (instr_m_access && !req_active) begin
         req_active = 1'b1;
         req_stale = 1'b0;
         req_addr = exp_addr(m_cs, m_ip);
         req_bs = m_ip[0] ? 2'b10 : 2'b11;
         chk("req_addr", instr_m_addr, req_addr);
         chk("req_bytesel", instr_m_bytesel, req_bs);
         addr_log.push_back(instr_m_addr);
         bs_log.push_back(instr_m_bytesel);
         n_fetch++;
         ack_wait = $urandom_range(ack_max, ack_min);
      end else if (req_active) begin
         chk("hold_access", instr_m_access, 1'b1);
         chk("hold_addr", instr_m_addr, req_addr);
         chk("hold_bytesel", instr_m_bytesel, req_bs);
      end

      if (stall_mode == 2 && $urandom_range(0, 9) == 0) stall_v = !stall_v;
      else if (stall_mode != 2) stall_v = (stall_mode == 1);
      ack = req_active && (ack_wait == 0);
      if (req_active && ack_wait > 0) ack_wait--;
      ld = force_ld || ($urandom_range(0, 99) < ld_pct);
      rd = $urandom_range(0, 99) < pop_pct;
      if (ld && !force_ld) begin
         lcs = 16'($urandom);
         lip = 16'($urandom);
      end
      load_new_ip = ld;
      new_cs = lcs;
      new_ip = lip;
      fifo_rd_en = rd;
      instr_m_ack = ack;
      instr_m_data_in = ack ? mem_word(instr_m_addr) : 16'($urandom);
`ifdef PREFETCH_STALL_EN
      stall_fetch = stall_v;
`endif

      start_exp = !instr_m_access && !ld && !stall_v &&
                  ((DEPTH - q.size()) >= (m_ip[0] ? 1 : 2));
      prev_access = instr_m_access;
      just_acked = ack;

      if (ld) begin
         q.delete();
         m_cs = lcs;
         m_ip = lip;
         if (req_active) req_stale = 1'b1;
      end else if (rd && q.size() > 0) begin
         void'(q.pop_front());
      end
      if (ack) begin
         if (!req_stale) begin
            w = mem_word(req_addr);
            if (req_bs == 2'b11) begin
               q.push_back(w[7:0]);
               q.push_back(w[15:8]);
               m_ip = m_ip + 16'd2;
            end else begin
               q.push_back(w[15:8]);
               m_ip = m_ip + 16'd1;
            end
         end
         req_active = 1'b0;
         req_stale = 1'b0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0);
   endtask

   task automatic wait_new_fetch(input string tag);
      int base, k;
      base = n_fetch;
      k = 0;
      while (n_fetch == base && k < 40) begin
         run(1);
         k++;
      end
      chk(tag, n_fetch != base, 1'b1);
   endtask

   initial begin
      int n0, k, sz;
      reset = 1'b1;
      load_new_ip = 1'b0;
      new_cs = 16'h0;
      new_ip = 16'h0;
      fifo_rd_en = 1'b0;
      instr_m_ack = 1'b0;
      instr_m_data_in = 16'h0;
`ifdef PREFETCH_STALL_EN
      stall_fetch = 1'b0;
`endif
      reset_dut();

      // boot fetch at FFFF0, two-cycle ack
      ack_min = 2;
      ack_max = 2;
      run(12);
      chk("t1_first_addr", addr_log[0], 19'h7FFF8);
      chk("t1_first_bs", bs_log[0], 2'b11);
      chk("t1_byte0", fifo_rd_data, 8'h12);
      pop_pct = 100;
      run(1);
      pop_pct = 0;
      run(1);
      chk("t1_byte1", fifo_rd_data, 8'h34);

      // fill to capacity with no pops
      ack_min = 0;
      ack_max = 3;
      step(1'b1, 16'h2000, 16'h0100);
      n0 = n_fetch;
      run(40);
      chk("t2_fetches", n_fetch - n0, 3);
      chk("t2_idle", instr_m_access, 1'b0);
      chk("t2_not_empty", fifo_empty, 1'b0);
      pop_pct = 100;
      run(2);
      pop_pct = 0;
      run(10);
      chk("t2_refill", n_fetch - n0, 4);

      // flush while a fetch is pending
      ack_min = 4;
      ack_max = 4;
      pop_pct = 100;
      k = 0;
      while (!(instr_m_access && req_active) && k < 20) begin
         run(1);
         k++;
      end
      chk("t3_pending", instr_m_access, 1'b1);
      pop_pct = 0;
      step(1'b1, 16'h1000, 16'h0003);
      ack_min = 0;
      ack_max = 3;
      wait_new_fetch("t3_fetch_a");
      sz = addr_log.size();
      chk("t3_addr_a", addr_log[sz-1], 19'h08001);
      chk("t3_bs_a", bs_log[sz-1], 2'b10);
      wait_new_fetch("t3_fetch_b");
      sz = addr_log.size();
      chk("t3_addr_b", addr_log[sz-1], 19'h08002);
      chk("t3_bs_b", bs_log[sz-1], 2'b11);

      // IP wrap inside segment 0
      pop_pct = 100;
      step(1'b1, 16'h0000, 16'hFFFE);
      wait_new_fetch("t4_fetch_a");
      sz = addr_log.size();
      chk("t4_addr_a", addr_log[sz-1], 19'h07FFF);
      wait_new_fetch("t4_fetch_b");
      sz = addr_log.size();
      chk("t4_addr_b", addr_log[sz-1], 19'h00000);

      // randomized traffic, with one reset in the middle of a bus cycle
      ld_pct = 3;
`ifdef PREFETCH_STALL_EN
      stall_mode = 2;
`endif
      for (int r = 0; r < 40; r++) begin
         pop_pct = $urandom_range(0, 100);
         run(50);
         if (r == 20) begin
            k = 0;
            while (!instr_m_access && k < 20) begin
               run(1);
               k++;
            end
            chk("mid_rst_pending", instr_m_access, 1'b1);
            reset_dut();
         end
      end
      ld_pct = 0;

`ifdef PREFETCH_STALL_EN
      // stall from reset, release, then stall mid-fetch
      stall_mode = 1;
      pop_pct = 50;
      reset_dut();
      n0 = n_fetch;
      run(10);
      chk("t6_stalled", n_fetch - n0, 0);
      stall_mode = 0;
      run(2);
      chk("t6_release", n_fetch - n0, 1);
      stall_mode = 1;
      ack_min = 2;
      ack_max = 2;
      run(15);
      chk("t6_one_only", n_fetch - n0, 1);
      chk("t6_access_low", instr_m_access, 1'b0);
      stall_mode = 0;
      run(20);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
